// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and access-size decode for lsu_align
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1, ST_RESP} lsu_state_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Doubleword and lwu exist only on a 64-bit datapath; unsigned forms are load-only.
    function automatic logic funct3_legal(input logic [2:0] funct3, input logic we, input logic is64);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_D:             ok = is64;
            F3_BU, F3_HU:     ok = !we;
            F3_WU:            ok = is64 && !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// rtl/lsu_extract.sv - merges up to two read beats, shifts the addressed bytes down and extends them
module lsu_extract #(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  beat0,
    input  logic [XLEN-1:0]  beat1,
    input  logic [OFF_W-1:0] off,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  rdata
);

    logic [XLEN-1:0] low;
    logic [XLEN-1:0] keep;
    logic            sbit;

    assign low = XLEN'({beat1, beat0} >> {off, 3'b000});

    always_comb begin
        keep = '1;
        sbit = 1'b0;
        case (funct3[1:0])
            2'b00: begin keep = XLEN'(8'hFF);         sbit = low[7];  end
            2'b01: begin keep = XLEN'(16'hFFFF);      sbit = low[15]; end
            2'b10: begin keep = XLEN'(32'hFFFF_FFFF); sbit = low[31]; end
            default: ;
        endcase
        rdata = (low & keep) | ((sbit && !funct3[2]) ? ~keep : '0);
    end

endmodule

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit: lane shifting, byte enables and two-beat split of misaligned accesses
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    lsu_state_t        state, state_nx;
    logic              we_q, err_q, cross_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q, rdata0_q, rdata_q;

    // Request-side decode, only consumed on the cycle the request is latched
    logic [4:0] end_off;
    logic       req_cross, req_err;

    assign end_off   = 5'(req_addr[OFF_W-1:0]) + 5'(size_bytes(req_funct3));
    assign req_cross = end_off > 5'(BYTES);
    assign req_err   = !funct3_legal(req_funct3, req_we, XLEN == 64) ||
                       (req_cross && (MISALIGN_SPLIT == 0));

    logic [OFF_W-1:0]   off_q;
    logic [ADDR_W-1:0]  base_addr;
    logic [2*BYTES-1:0] be_wide;
    logic [2*XLEN-1:0]  wdata_wide;
    logic               beat1_sel;

    assign off_q      = addr_q[OFF_W-1:0];
    assign base_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign be_wide    = ((2*BYTES)'((16'h1 << size_bytes(f3_q)) - 16'h1)) << off_q;
    assign wdata_wide = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
    assign beat1_sel  = (state == ST_BEAT1);

    // Beat outputs come only from state and latched fields, so they hold while mem_ready is low
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign mem_valid  = (state == ST_BEAT0) || beat1_sel;
    assign mem_we     = mem_valid && we_q;
    assign mem_addr   = !mem_valid ? '0 : (beat1_sel ? base_addr + ADDR_W'(BYTES) : base_addr);
    assign mem_be     = !mem_valid ? '0 : (beat1_sel ? be_wide[2*BYTES-1:BYTES] : be_wide[BYTES-1:0]);
    assign mem_wdata  = (!mem_valid || !we_q) ? '0 :
                        (beat1_sel ? wdata_wide[2*XLEN-1:XLEN] : wdata_wide[XLEN-1:0]);

    logic [XLEN-1:0] ext_b0, ext_b1, ext_data;

    assign ext_b0 = beat1_sel ? rdata0_q : mem_rdata;
    assign ext_b1 = beat1_sel ? mem_rdata : '0;

    lsu_extract #(.XLEN(XLEN)) u_extract (
        .beat0  (ext_b0),
        .beat1  (ext_b1),
        .off    (off_q),
        .funct3 (f3_q),
        .rdata  (ext_data)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (req_valid) state_nx = req_err ? ST_RESP : ST_BEAT0;
            ST_BEAT0: if (mem_ready) state_nx = cross_q ? ST_BEAT1 : ST_RESP;
            ST_BEAT1: if (mem_ready) state_nx = ST_RESP;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cross_q  <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req_valid) begin
                we_q    <= req_we;
                err_q   <= req_err;
                cross_q <= req_cross;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end
            if (state == ST_BEAT0 && mem_ready)
                rdata0_q <= mem_rdata;
            // Final beat of a load: merge with the held first beat if there was one
            if (mem_valid && mem_ready && !we_q && state_nx == ST_RESP)
                rdata_q <= ext_data;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - self-checking bench for lsu_align (32-bit split, 32-bit reject, 64-bit split)
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    logic        n_rdy [2], n_rv [2], n_err [2], n_mv [2], n_mwe [2];
    logic [31:0] n_rdata [2], n_maddr [2], n_mwdata [2];
    logic [3:0]  n_mbe [2];
    logic        w_rdy, w_rv, w_err, w_mv, w_mwe;
    logic [63:0] w_rdata, w_mwdata;
    logic [31:0] w_maddr;
    logic [7:0]  w_mbe;

    logic        cur_rdy, cur_rv, cur_err, cur_mv, cur_mwe;
    logic [63:0] cur_rdata, cur_mwdata;
    logic [31:0] cur_maddr;
    logic [7:0]  cur_mbe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g32
        lsu_align #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1 - g)) dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid && sel == 2'(g)),
            .req_ready  (n_rdy[g]),
            .req_we     (req_we),
            .req_funct3 (req_funct3),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata[31:0]),
            .resp_valid (n_rv[g]),
            .resp_rdata (n_rdata[g]),
            .resp_err   (n_err[g]),
            .mem_valid  (n_mv[g]),
            .mem_ready  (mem_ready),
            .mem_we     (n_mwe[g]),
            .mem_addr   (n_maddr[g]),
            .mem_be     (n_mbe[g]),
            .mem_wdata  (n_mwdata[g]),
            .mem_rdata  (mem_rdata[31:0])
        );
    end

    lsu_align #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut64 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid && sel == 2'd2),
        .req_ready  (w_rdy),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (w_rv),
        .resp_rdata (w_rdata),
        .resp_err   (w_err),
        .mem_valid  (w_mv),
        .mem_ready  (mem_ready),
        .mem_we     (w_mwe),
        .mem_addr   (w_maddr),
        .mem_be     (w_mbe),
        .mem_wdata  (w_mwdata),
        .mem_rdata  (mem_rdata)
    );

    always_comb begin
        if (sel == 2'd2) begin
            cur_rdy = w_rdy;  cur_rv = w_rv;  cur_err = w_err;  cur_mv = w_mv;  cur_mwe = w_mwe;
            cur_rdata = w_rdata;  cur_mwdata = w_mwdata;  cur_maddr = w_maddr;  cur_mbe = w_mbe;
        end else begin
            cur_rdy = n_rdy[sel[0]];  cur_rv = n_rv[sel[0]];  cur_err = n_err[sel[0]];
            cur_mv = n_mv[sel[0]];  cur_mwe = n_mwe[sel[0]];
            cur_rdata = 64'(n_rdata[sel[0]]);  cur_mwdata = 64'(n_mwdata[sel[0]]);
            cur_maddr = n_maddr[sel[0]];  cur_mbe = 8'(n_mbe[sel[0]]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Byte-addressed memory behind the DUT and the reference copy kept by the model
    logic [7:0]  dmem [1024];
    logic [7:0]  ref_mem [1024];
    logic [31:0] bq_addr [$];
    logic [7:0]  bq_be [$];
    logic [63:0] bq_wd [$];
    int          wait_cfg = 0;
    int          stalls = 0;

    logic        in_beat;
    int          stall_left;
    logic [31:0] snap_addr;
    logic [7:0]  snap_be;
    logic [63:0] snap_wd;
    logic        snap_we;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        in_beat = 1'b0;
        stall_left = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!cur_mv) begin
                in_beat = 1'b0;
            end else begin
                if (!in_beat) begin
                    in_beat = 1'b1;
                    stall_left = (wait_cfg < 0) ? int'($urandom_range(0, 2)) : wait_cfg;
                    snap_addr = cur_maddr;  snap_be = cur_mbe;  snap_wd = cur_mwdata;  snap_we = cur_mwe;
                    chk("mem_addr_align", 64'(cur_maddr % ((sel == 2'd2) ? 32'd8 : 32'd4)), 64'd0);
                end else begin
                    chk("stall_addr", 64'(cur_maddr), 64'(snap_addr));
                    chk("stall_be", 64'(cur_mbe), 64'(snap_be));
                    chk("stall_wdata", cur_mwdata, snap_wd);
                    chk("stall_we", 64'(cur_mwe), 64'(snap_we));
                end
                if (stall_left == 0) begin
                    mem_ready = 1'b1;
                    in_beat = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        mem_rdata[8*i +: 8] = dmem[int'((cur_maddr + 32'(i)) & 32'h3FF)];
                        if (cur_mwe && cur_mbe[i])
                            dmem[int'((cur_maddr + 32'(i)) & 32'h3FF)] = cur_mwdata[8*i +: 8];
                    end
                    bq_addr.push_back(cur_maddr);
                    bq_be.push_back(cur_mbe);
                    bq_wd.push_back(cur_mwdata);
                end else begin
                    stall_left--;
                    stalls++;
                end
            end
        end
    end

    // Reference: access semantics straight from the byte-addressed memory image
    function automatic void model(input logic [1:0] s, input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [63:0] wd,
                                  output logic er, output int nbeats, output logic [63:0] rd);
        int nb, size, off;
        logic legal;
        logic [63:0] v;
        nb = (s == 2'd2) ? 8 : 4;
        size = 1 << f3[1:0];
        off = int'(a % 32'(nb));
        case (f3)
            3'd0, 3'd1, 3'd2: legal = 1'b1;
            3'd3:             legal = (nb == 8);
            3'd4, 3'd5:       legal = !we;
            3'd6:             legal = !we && nb == 8;
            default:          legal = 1'b0;
        endcase
        er = !legal || (off + size > nb && s == 2'd1);
        nbeats = er ? 0 : ((off + size > nb) ? 2 : 1);
        rd = '0;
        v = '0;
        if (!er) begin
            for (int b = 0; b < size; b++) begin
                if (we) ref_mem[int'((a + 32'(b)) & 32'h3FF)] = wd[8*b +: 8];
                else    v[8*b +: 8] = ref_mem[int'((a + 32'(b)) & 32'h3FF)];
            end
            if (!we) begin
                if (!f3[2] && v[8*size-1])
                    for (int b = size; b < 8; b++) v[8*b +: 8] = 8'hFF;
                if (nb == 4) v[63:32] = '0;
                rd = v;
            end
        end
    endfunction

    task automatic access(input logic [1:0] s, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [63:0] wd,
                          output int lat, output logic [63:0] rd, output logic er);
        logic seen;
        @(negedge clk);
        sel = s;  req_we = we;  req_funct3 = f3;  req_addr = a;  req_wdata = wd;  req_valid = 1'b1;
        bq_addr.delete();  bq_be.delete();  bq_wd.delete();
        stalls = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;  rd = '0;  er = 1'b0;  seen = 1'b0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (cur_rv) begin
                seen = 1'b1;  rd = cur_rdata;  er = cur_err;
            end
        end
        chk("resp_seen", 64'(seen), 64'd1);
        @(negedge clk);
        chk("resp_one_cycle", 64'(cur_rv), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  s;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic [7:0]  be0;
        int          nb;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, e_nb, mism, bad_resp;
        logic [63:0] rd, e_rd;
        logic er, e_er;
        logic [31:0] ra;
        logic [2:0] rf;
        logic rw;
        logic [1:0] rs;
        logic [63:0] rwd;

        reset = 1'b0;  sel = 2'd0;  req_valid = 1'b0;  req_we = 1'b0;
        req_funct3 = '0;  req_addr = '0;  req_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            dmem[i] = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        for (int i = 0; i < 4; i++) begin
            ra = 32'h80FF_1234;
            dmem[32'h60 + i] = ra[8*i +: 8];
            ref_mem[32'h60 + i] = ra[8*i +: 8];
        end
        for (int i = 0; i < 16; i++) begin
            dmem[32'h100 + i] = 8'(8'hA0 + i);
            ref_mem[32'h100 + i] = 8'(8'hA0 + i);
        end

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_req_ready", 64'(cur_rdy), 64'd1);
            chk("rst_resp_valid", 64'(cur_rv), 64'd0);
            chk("rst_resp_err", 64'(cur_err), 64'd0);
            chk("rst_resp_rdata", cur_rdata, 64'd0);
            chk("rst_mem_valid", 64'(cur_mv), 64'd0);
            chk("rst_mem_we", 64'(cur_mwe), 64'd0);
            chk("rst_mem_be", 64'(cur_mbe), 64'd0);
            chk("rst_mem_addr", 64'(cur_maddr), 64'd0);
            chk("rst_mem_wdata", cur_mwdata, 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        vt[0]  = '{2'd0, 1'b0, 3'b000, 32'h63,  64'hFFFF_FF80, 1'b0, 2, 8'h08, 1};
        vt[1]  = '{2'd0, 1'b0, 3'b101, 32'h62,  64'h0000_80FF, 1'b0, 2, 8'h0C, 1};
        vt[2]  = '{2'd0, 1'b0, 3'b001, 32'h62,  64'hFFFF_80FF, 1'b0, 2, 8'h0C, 1};
        vt[3]  = '{2'd0, 1'b0, 3'b010, 32'h60,  64'h80FF_1234, 1'b0, 2, 8'h0F, 1};
        vt[4]  = '{2'd0, 1'b0, 3'b100, 32'h61,  64'h0000_0012, 1'b0, 2, 8'h02, 1};
        vt[5]  = '{2'd1, 1'b0, 3'b010, 32'h60,  64'h80FF_1234, 1'b0, 2, 8'h0F, 1};
        vt[6]  = '{2'd1, 1'b1, 3'b001, 32'h63,  64'h0,         1'b1, 1, 8'h00, 0};
        vt[7]  = '{2'd1, 1'b0, 3'b111, 32'h60,  64'h0,         1'b1, 1, 8'h00, 0};
        vt[8]  = '{2'd0, 1'b0, 3'b011, 32'h60,  64'h0,         1'b1, 1, 8'h00, 0};
        vt[9]  = '{2'd0, 1'b1, 3'b100, 32'h60,  64'h0,         1'b1, 1, 8'h00, 0};
        vt[10] = '{2'd2, 1'b0, 3'b010, 32'h104, 64'hFFFF_FFFF_A7A6_A5A4, 1'b0, 2, 8'hF0, 1};
        vt[11] = '{2'd2, 1'b0, 3'b110, 32'h104, 64'h0000_0000_A7A6_A5A4, 1'b0, 2, 8'hF0, 1};

        wait_cfg = 0;
        for (int i = 0; i < NV; i++) begin
            access(vt[i].s, vt[i].we, vt[i].f3, vt[i].addr, 64'hBEEF, lat, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].er));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("vec%0d_beats", i), 64'(bq_addr.size()), 64'(vt[i].nb));
            if (vt[i].nb > 0 && bq_be.size() > 0)
                chk($sformatf("vec%0d_be0", i), 64'(bq_be[0]), 64'(vt[i].be0));
        end

        // Split store across a word boundary
        model(2'd0, 1'b1, 3'b001, 32'h63, 64'hBEEF, e_er, e_nb, e_rd);
        access(2'd0, 1'b1, 3'b001, 32'h63, 64'hBEEF, lat, rd, er);
        chk("sh_lat", 64'(lat), 64'd3);
        chk("sh_err", 64'(er), 64'd0);
        chk("sh_rdata", rd, 64'd0);
        chk("sh_beats", 64'(bq_addr.size()), 64'd2);
        if (bq_addr.size() == 2) begin
            chk("sh_b0_addr", 64'(bq_addr[0]), 64'h60);
            chk("sh_b0_be", 64'(bq_be[0]), 64'h8);
            chk("sh_b0_wdata", bq_wd[0], 64'hEF00_0000);
            chk("sh_b1_addr", 64'(bq_addr[1]), 64'h64);
            chk("sh_b1_be", 64'(bq_be[1]), 64'h1);
            chk("sh_b1_wdata", bq_wd[1], 64'h0000_00BE);
        end
        access(2'd0, 1'b0, 3'b010, 32'h60, 64'h0, lat, rd, er);
        chk("sh_readback", rd, 64'hEFFF_1234);

        // 64-bit doubleword crossing two beats, three wait states on each
        wait_cfg = 3;
        access(2'd2, 1'b0, 3'b011, 32'h104, 64'h0, lat, rd, er);
        chk("ld_lat", 64'(lat), 64'd9);
        chk("ld_rdata", rd, 64'hABAA_A9A8_A7A6_A5A4);
        chk("ld_err", 64'(er), 64'd0);
        chk("ld_beats", 64'(bq_addr.size()), 64'd2);
        if (bq_addr.size() == 2) begin
            chk("ld_b0_addr", 64'(bq_addr[0]), 64'h100);
            chk("ld_b0_be", 64'(bq_be[0]), 64'hF0);
            chk("ld_b1_addr", 64'(bq_addr[1]), 64'h108);
            chk("ld_b1_be", 64'(bq_be[1]), 64'h0F);
        end

        // Asynchronous reset while the second beat is stalled
        @(negedge clk);
        sel = 2'd0;  req_we = 1'b0;  req_funct3 = 3'b010;  req_addr = 32'h62;  req_valid = 1'b1;
        bq_addr.delete();  bq_be.delete();  bq_wd.delete();
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_in_beat1", 64'(cur_mv), 64'd1);
        chk("rst_mid_beat0_done", 64'(bq_addr.size()), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_mem_valid", 64'(cur_mv), 64'd0);
        chk("rst_async_req_ready", 64'(cur_rdy), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad_resp = 0;
        repeat (5) begin
            @(negedge clk);
            if (cur_rv || cur_mv) bad_resp++;
        end
        chk("rst_no_resp", 64'(bad_resp), 64'd0);
        chk("rst_after_ready", 64'(cur_rdy), 64'd1);
        wait_cfg = 0;
        access(2'd0, 1'b0, 3'b010, 32'h60, 64'h0, lat, rd, er);
        chk("rst_fresh_lw_rdata", rd, 64'hEFFF_1234);
        chk("rst_fresh_lw_lat", 64'(lat), 64'd2);

        // Randomised accesses against the reference model
        wait_cfg = -1;
        for (int n = 0; n < 300; n++) begin
            rs = 2'($urandom_range(0, 2));
            rw = 1'($urandom_range(0, 1));
            rf = 3'($urandom_range(0, 7));
            ra = 32'h200 + 32'($urandom_range(0, 511));
            rwd = {$urandom, $urandom};
            model(rs, rw, rf, ra, rwd, e_er, e_nb, e_rd);
            access(rs, rw, rf, ra, rwd, lat, rd, er);
            chk($sformatf("rnd%0d_rdata", n), rd, e_rd);
            chk($sformatf("rnd%0d_err", n), 64'(er), 64'(e_er));
            chk($sformatf("rnd%0d_beats", n), 64'(bq_addr.size()), 64'(e_nb));
            chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(e_er ? 1 : 1 + e_nb + stalls));
        end

        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (dmem[i] !== ref_mem[i]) mism++;
        chk("mem_image", 64'(mism), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
# lsu_align

Parametrised load/store alignment unit between the core's execute stage and the data-memory port. Handles byte, halfword, word and (when XLEN=64) doubleword accesses with sign/zero extension and per-byte write enables. Misaligned accesses are either split into two memory beats or rejected, under a valid/ready handshake to a memory with wait states. Successor to the fixed 32-bit, single-cycle, word-only load path.

## Interface
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.
- MISALIGN_SPLIT, 1: 1 = split boundary-crossing accesses into two beats; 0 = reject them with resp_err.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- req_valid  in  1  core access request.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid.
- mem_valid  out  1  memory beat request.
- mem_ready  in  1  beat accepted; for reads, mem_rdata is valid this cycle.
- mem_we  out  1  write beat.
- mem_addr  out  ADDR_W  XLEN/8-aligned address; low log2(XLEN/8) bits are 0.
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rdata  in  XLEN  read data.

## Operation
- Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. XLEN=64 adds 011 ld and 110 lwu.
- Stores: 000 sb, 001 sh, 010 sw. XLEN=64 adds 011 sd.
- Any other funct3 is illegal.
- Size bytes S = 1, 2, 4 or 8. Offset off = req_addr mod (XLEN/8).
- Crossing: off + S > XLEN/8.
- Byte-enable mask m = ((1<<S)-1) << off, computed 2*XLEN/8 wide.
  - beat0 mem_be = low half of m, at word A0 = req_addr with offset bits cleared.
  - beat1 mem_be = high half of m, at A0 + XLEN/8.
- Store data: {XLEN'0, wdata} << 8*off; beat0 takes the low half, beat1 the high half.
- Load data: beat0 data is captured into a register. Merged = {beat1 data (0 if single beat), beat0 data} >> 8*off. Take the low S bytes. Sign-extend for lb/lh/lw(XLEN=64)/ld; zero-extend for unsigned loads.
- Error cases: resp_err=1, no memory beat issued.
  - illegal funct3;
  - crossing access with MISALIGN_SPLIT=0.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: on req_valid, latch the request. Illegal -> RESP with err. Otherwise -> BEAT0.
  - BEAT0: mem_valid=1. On mem_ready: crossing -> BEAT1; else -> RESP.
  - BEAT1: mem_valid=1. On mem_ready -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Once mem_valid is raised, it and all mem_* outputs hold stable until mem_ready. No withdrawal.

## Timing
- Reset (asserted low): state=IDLE. Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Reset is asynchronous: mem_valid drops immediately; an in-flight access produces no response; a beat in flight is abandoned.
- Request accepted at cycle N (req_valid & req_ready).
  - Aligned, zero wait states: mem_valid at N+1, resp_valid at N+2.
  - Crossing: beats at N+1 and N+2, resp_valid at N+3.
  - Error: resp_valid at N+1.
- Each memory wait cycle (mem_valid & !mem_ready) adds one cycle.
- One access outstanding at a time; next accept earliest the cycle after resp_valid.
- All outputs are registered, or decoded from state plus registered fields; no combinational path from req_* to mem_*.

## Structure
- lsu_pkg: funct3 localparams, state enum (IDLE/BEAT0/BEAT1/RESP), size decode function.
- Sub-module lsu_extract: combinational merge, shift and extend of load data. Parameterised by XLEN.

## Test plan
- XLEN=32, lb at 0x63, memory word at 0x60 = 0x80FF_1234, mem_ready=1 -> one beat, mem_be=4'b1000, resp_rdata=0xFFFF_FF80 at N+2.
- lhu at 0x62, same word -> mem_be=4'b1100, resp_rdata=0x0000_80FF.
- sh 0xBEEF at 0x63, MISALIGN_SPLIT=1 -> beats:
  - beat0 addr 0x60, be=1000, wdata=0xEF00_0000;
  - beat1 addr 0x64, be=0001, wdata=0x0000_00BE;
  - resp_valid at N+3.
- Same sh with MISALIGN_SPLIT=0 -> no mem_valid, resp_err=1 at N+1. funct3=111 load gives the same result.
- XLEN=64, ld at 0x104, mem_ready stalled 3 cycles per beat -> mem_* outputs stable while stalled; data merged across both beats; resp_valid at N+9.
- reset driven low during BEAT1 -> mem_valid=0 immediately, no resp_valid; after release, req_ready=1 and a fresh lw completes normally.
